// File: rtl/m72_clk_pkg.sv
// Shared clocking definitions for the M72 core: sequencer states and the
// nominal clock ratios reused by the video and audio timing blocks.
package m72_clk_pkg;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_COUNT = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam int unsigned SYS_CLK_HZ = 96_000_000;
    localparam int unsigned CPU_CLK_HZ = 8_000_000;
    localparam int unsigned SND_CLK_HZ = 3_579_545;

    localparam int unsigned DEF_CPU_DIV = SYS_CLK_HZ / CPU_CLK_HZ;
    localparam int unsigned DEF_SND_NUM = SND_CLK_HZ;
    localparam int unsigned DEF_SND_DEN = SYS_CLK_HZ;

    localparam int unsigned DIV_W  = 8;
    localparam int unsigned ACC_W  = 28;
    localparam int unsigned RCNT_W = 16;

endpackage

// File: rtl/frac_ce.sv
// Fractional clock enable: one-cycle pulses at clk*NUM/DEN using a phase
// accumulator that is cleared whenever run is low and frozen while paused.
module frac_ce #(
    parameter int unsigned NUM = 3_579_545,
    parameter int unsigned DEN = 96_000_000,
    parameter int unsigned W   = 28
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic pause,
    output logic ce
);

    localparam logic [W-1:0] NUM_W = W'(NUM);
    localparam logic [W-1:0] DEN_W = W'(DEN);

    logic [W-1:0] acc;
    logic [W-1:0] sum;

    // NUM < DEN < 2^(W-1), so acc + NUM never wraps the W-bit adder.
    assign sum = acc + NUM_W;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            ce  <= 1'b0;
        end else if (!run) begin
            acc <= '0;
            ce  <= 1'b0;
        end else if (pause) begin
            ce  <= 1'b0;
        end else if (sum >= DEN_W) begin
            acc <= sum - DEN_W;
            ce  <= 1'b1;
        end else begin
            acc <= sum;
            ce  <= 1'b0;
        end
    end

endmodule

// File: rtl/m72_clock_enables.sv
// Reset sequencer and clock-enable generator behind the system PLL: holds the
// core in reset until lock has been stable, then emits CPU and sound enables.
module m72_clock_enables
    import m72_clk_pkg::*;
#(
    parameter int unsigned CPU_DIV      = DEF_CPU_DIV,
    parameter int unsigned SND_NUM      = DEF_SND_NUM,
    parameter int unsigned SND_DEN      = DEF_SND_DEN,
    parameter int unsigned RESET_CYCLES = 1024,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic pll_locked,
    input  logic soft_reset,
    input  logic pause,
    output logic core_reset_n,
    output logic ce_cpu,
    output logic ce_snd,
    output logic running
);

    localparam logic [DIV_W-1:0]  CPU_LAST = DIV_W'(CPU_DIV - 1);
    localparam logic [RCNT_W-1:0] RST_LAST = RCNT_W'(RESET_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    state_t                 state, state_nxt;
    logic [RCNT_W-1:0]      rst_cnt, rst_cnt_nxt;
    logic                   run_en;
    logic [DIV_W-1:0]       cpu_cnt;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_nxt   = state;
        rst_cnt_nxt = rst_cnt;
        if (!lock_s) begin
            state_nxt   = ST_HOLD;
            rst_cnt_nxt = '0;
        end else begin
            case (state)
                ST_HOLD: begin
                    state_nxt   = ST_COUNT;
                    rst_cnt_nxt = '0;
                end
                ST_COUNT: begin
                    if (soft_reset) begin
                        rst_cnt_nxt = '0;
                    end else if (rst_cnt == RST_LAST) begin
                        state_nxt   = ST_RUN;
                        rst_cnt_nxt = '0;
                    end else begin
                        rst_cnt_nxt = rst_cnt + RCNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (soft_reset) begin
                        state_nxt   = ST_COUNT;
                        rst_cnt_nxt = '0;
                    end
                end
                default: begin
                    state_nxt   = ST_HOLD;
                    rst_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_HOLD;
            rst_cnt      <= '0;
            core_reset_n <= 1'b0;
            running      <= 1'b0;
        end else begin
            state        <= state_nxt;
            rst_cnt      <= rst_cnt_nxt;
            core_reset_n <= (state == ST_RUN);
            running      <= (state == ST_RUN);
        end
    end

    // Enable logic only advances while RUN persists across this edge, so the
    // enables drop on the very edge that leaves RUN and start from phase 0.
    assign run_en = (state == ST_RUN) && (state_nxt == ST_RUN);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cpu_cnt <= '0;
            ce_cpu  <= 1'b0;
        end else if (!run_en) begin
            cpu_cnt <= '0;
            ce_cpu  <= 1'b0;
        end else if (pause) begin
            ce_cpu  <= 1'b0;
        end else begin
            ce_cpu  <= (cpu_cnt == CPU_LAST);
            cpu_cnt <= (cpu_cnt == CPU_LAST) ? '0 : cpu_cnt + DIV_W'(1);
        end
    end

    frac_ce #(
        .NUM (SND_NUM),
        .DEN (SND_DEN),
        .W   (ACC_W)
    ) u_snd_ce (
        .clk   (clk_sys),
        .rst_n (reset_n),
        .run   (run_en),
        .pause (pause),
        .ce    (ce_snd)
    );

endmodule

// File: tb/tb_m72_clock_enables.sv
// Directed bench for m72_clock_enables at default parameters: lock-up latency,
// enable rates, pause, lock loss, soft reset and asynchronous reset.
module tb_m72_clock_enables;

    logic clk_sys = 1'b0;
    logic reset_n, pll_locked, soft_reset, pause;
    logic core_reset_n, ce_cpu, ce_snd, running;

    int n_assert = 0;
    int n_fail   = 0;

    int n, first_cpu, first_snd;
    int cpu_n, cpu_n1200, snd_n, last_cpu, last_snd, bad_cpu_gap, bad_snd_gap;
    int gap, stray;

    always #5 clk_sys = ~clk_sys;

    m72_clock_enables dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .pll_locked   (pll_locked),
        .soft_reset   (soft_reset),
        .pause        (pause),
        .core_reset_n (core_reset_n),
        .ce_cpu       (ce_cpu),
        .ce_snd       (ce_snd),
        .running      (running)
    );

    task automatic step(input int cycles);
        repeat (cycles) @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
        n_assert++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic wait_core_up(input string tag, input int exp);
        int k = 0;
        while (core_reset_n !== 1'b1 && k < 1500) begin
            step(1);
            k++;
        end
        check(tag, k, exp);
    endtask

    initial begin
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        soft_reset = 1'b0;
        pause      = 1'b0;
        step(3);
        check("rst_core", core_reset_n, 0);
        check("rst_running", running, 0);
        check("rst_ce_cpu", ce_cpu, 0);
        check("rst_ce_snd", ce_snd, 0);

        reset_n = 1'b1;
        step(20);
        check("nolock_core", core_reset_n, 0);

        // Lock rises just after an edge: 2 sync + 1 to COUNT + 1024 + 1 output.
        pll_locked = 1'b1;
        wait_core_up("lockup_edges", 1028);
        check("lockup_running", running, 1);

        // Already one edge past RUN entry: ce_cpu at entry+12, ce_snd at entry+27.
        first_cpu = -1;
        first_snd = -1;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            if (ce_cpu && first_cpu < 0) first_cpu = i;
            if (ce_snd && first_snd < 0) first_snd = i;
        end
        check("first_ce_cpu", first_cpu, 11);
        check("first_ce_snd", first_snd, 26);

        cpu_n = 0; cpu_n1200 = 0; snd_n = 0;
        last_cpu = -1; last_snd = -1; bad_cpu_gap = 0; bad_snd_gap = 0;
        for (int i = 0; i < 48000; i++) begin
            step(1);
            if (ce_cpu) begin
                cpu_n++;
                if (i < 1200) cpu_n1200++;
                if (last_cpu >= 0 && i - last_cpu != 12) bad_cpu_gap++;
                last_cpu = i;
            end
            if (ce_snd) begin
                snd_n++;
                if (last_snd >= 0 && i - last_snd != 26 && i - last_snd != 27) bad_snd_gap++;
                last_snd = i;
            end
        end
        check("cpu_pulses_1200", cpu_n1200, 100);
        check("cpu_pulses_48000", cpu_n, 4000);
        check("cpu_gaps", bad_cpu_gap, 0);
        check_rng("snd_pulses_48000", snd_n, 1789, 1790);
        check("snd_gaps", bad_snd_gap, 0);

        // Pause for 37 edges, 5 edges after a ce_cpu pulse.
        n = 0;
        while (ce_cpu !== 1'b1 && n < 20) begin
            step(1);
            n++;
        end
        check("pause_sync_found", ce_cpu, 1);
        step(5);
        gap = 5;
        pause = 1'b1;
        stray = 0;
        for (int i = 0; i < 37; i++) begin
            step(1);
            gap++;
            if (ce_cpu || ce_snd) stray++;
        end
        pause = 1'b0;
        check("pause_no_pulses", stray, 0);
        while (ce_cpu !== 1'b1 && gap < 100) begin
            step(1);
            gap++;
        end
        check("pause_cpu_gap", gap, 49);

        // Lock loss: 2 sync edges, HOLD on the 3rd, output on the 4th.
        step(7);
        pll_locked = 1'b0;
        n = 0;
        stray = 0;
        while (core_reset_n === 1'b1 && n < 10) begin
            step(1);
            n++;
            if (n >= 3 && (ce_cpu || ce_snd)) stray++;
        end
        check("lockloss_edges", n, 4);
        check("lockloss_running", running, 0);
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (ce_cpu || ce_snd) stray++;
        end
        check("lockloss_enables_stop", stray, 0);

        pll_locked = 1'b1;
        wait_core_up("relock_edges", 1028);

        // Single-cycle soft reset: core_reset_n lags one edge, then 1024 more.
        step(50);
        soft_reset = 1'b1;
        step(1);
        soft_reset = 1'b0;
        check("soft_lag_core", core_reset_n, 1);
        step(1);
        check("soft_core_low", core_reset_n, 0);
        check("soft_running_low", running, 0);
        wait_core_up("soft_pulse_edges", 1024);

        // Held soft reset: release counts from the last high edge.
        step(50);
        soft_reset = 1'b1;
        step(60);
        check("soft_held_core", core_reset_n, 0);
        soft_reset = 1'b0;
        wait_core_up("soft_held_edges", 1025);

        // Asynchronous reset between edges while running.
        step(30);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_run_core", core_reset_n, 0);
        check("async_run_running", running, 0);
        check("async_run_ce_cpu", ce_cpu, 0);
        check("async_run_ce_snd", ce_snd, 0);
        step(1);
        #3;
        reset_n = 1'b1;
        step(500);
        check("count_core_low", core_reset_n, 0);

        // Asynchronous reset mid-COUNT must restart the whole sequence.
        #3;
        reset_n = 1'b0;
        #1;
        check("async_count_core", core_reset_n, 0);
        check("async_count_ce_cpu", ce_cpu, 0);
        step(2);
        #3;
        reset_n = 1'b1;
        wait_core_up("restart_edges", 1028);
        check("restart_running", running, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
